// File: rtl/mac_pe_param.sv
// -----------------------------------------------------------------------------
// mac_pe_param
//
// Parametrised multiply-accumulate processing element for a systolic array.
// One instance per array cell. Activation and weight are forwarded right/down
// through registered ports; the arithmetic runs in one of two dataflow modes:
//
//   mode 0 (pass-sum)          : psum_out <= psum_in + act*wgt every active cycle
//   mode 1 (output-stationary) : a local accumulator collects act*wgt and is
//                                drained onto psum_out over a valid/ready
//                                handshake (double-buffered: accumulation goes
//                                on while a drained value waits downstream)
//
// Parameters
//   DATA_W   signed activation/weight width
//   ACC_W    signed accumulator / partial-sum width (>= 2*DATA_W+1)
//   SATURATE 1 = clamp on overflow, 0 = two's-complement wrap
//   CNT_W    zero-skip counter width
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   en, row_en, col_en  PE is active only when all three are 1;
//                       en alone also gates the operand forwarding
//   mode                0 = pass-sum, 1 = output-stationary (change under reset)
//   act_in, wgt_in      signed operands
//   act_out, wgt_out    registered forward of act_in / wgt_in
//   psum_in             upstream partial sum (mode 0)
//   psum_out            mode 0: registered sum; mode 1: drained accumulator
//   acc_clr, drain_req  mode 1 accumulator clear / drain request
//   out_valid, out_ready drain handshake (mode 1)
//   sat_flag            sticky overflow indicator
//   skip_cnt            saturating count of active cycles with a zero operand
// -----------------------------------------------------------------------------
module mac_pe_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     row_en,
    input  logic                     col_en,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] act_in,
    input  logic signed [DATA_W-1:0] wgt_in,
    output logic signed [DATA_W-1:0] act_out,
    output logic signed [DATA_W-1:0] wgt_out,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [ACC_W-1:0]  psum_out,
    input  logic                     acc_clr,
    input  logic                     drain_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag,
    output logic [CNT_W-1:0]         skip_cnt
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Signed add with overflow detection.
    // Returns {overflow, result}. The sum is formed one bit wider so overflow
    // shows up as a disagreement of the two top bits; the wide sign bit tells
    // which rail to clamp to. With SATURATE=0 the low bits (the wrapped value)
    // are returned but overflow is still reported for the sticky flag.
    // -------------------------------------------------------------------------
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W:0]   wide;
        logic             ovf;
        logic [ACC_W-1:0] res;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        res  = wide[ACC_W-1:0];
        if (ovf && SATURATE) begin
            res = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return {ovf, res};
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] act_out_q, act_out_d;
    logic signed [DATA_W-1:0] wgt_out_q, wgt_out_d;
    logic signed [ACC_W-1:0]  psum_q,    psum_d;
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q,     sat_d;
    logic [CNT_W-1:0]         skip_q,    skip_d;
    state_t                   state_q,   state_d;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic                     active;
    logic                     zero;
    logic signed [DATA_W-1:0] act_g;
    logic signed [DATA_W-1:0] wgt_g;
    logic signed [PROD_W-1:0] act_x;
    logic signed [PROD_W-1:0] wgt_x;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_term;
    logic signed [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]           pass_res;
    logic [ACC_W:0]           acc_res;

    always_comb begin
        active = en & row_en & col_en;
        zero   = (act_in == '0) | (wgt_in == '0);

        // Operand gating: a zero operand keeps the multiplier inputs quiet,
        // which also makes the product exactly 0.
        act_g = zero ? '0 : act_in;
        wgt_g = zero ? '0 : wgt_in;

        // Multiply at full product width with explicitly sign-extended
        // operands, so no implicit width promotion is involved.
        act_x     = {{DATA_W{act_g[DATA_W-1]}}, act_g};
        wgt_x     = {{DATA_W{wgt_g[DATA_W-1]}}, wgt_g};
        prod_full = act_x * wgt_x;
        prod_ext  = {{(ACC_W-PROD_W){prod_full[PROD_W-1]}}, prod_full};

        // Mode 1 adder: the clear drops the old accumulator value but still
        // admits the current product. The same result serves as the next
        // accumulator value and as the drained value, so one adder suffices.
        add_term = active ? prod_ext : '0;
        acc_base = acc_clr ? '0 : acc_q;

        pass_res = sat_add(psum_in, prod_ext);
        acc_res  = sat_add(acc_base, add_term);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        act_out_d   = act_out_q;
        wgt_out_d   = wgt_out_q;
        psum_d      = psum_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        skip_d      = skip_q;
        state_d     = state_q;

        // Forwarding depends only on the global enable.
        if (en) begin
            act_out_d = act_in;
            wgt_out_d = wgt_in;
        end

        // Sparsity statistics, saturating at all-ones.
        if (active && zero && (skip_q != {CNT_W{1'b1}})) begin
            skip_d = skip_q + 1'b1;
        end

        if (!mode) begin
            // Pass-sum. A zero operand gives prod 0, so the sum is psum_in
            // exactly and cannot overflow.
            state_d     = ST_ACC;
            out_valid_d = 1'b0;
            if (active) begin
                psum_d = pass_res[ACC_W-1:0];
                sat_d  = sat_q | pass_res[ACC_W];
            end
        end else begin
            // Output-stationary. Accumulation continues in both states; when
            // inactive and not clearing, acc_res equals acc_q.
            acc_d = acc_res[ACC_W-1:0];
            sat_d = (acc_clr ? 1'b0 : sat_q) | acc_res[ACC_W];

            unique case (state_q)
                ST_ACC: begin
                    if (drain_req) begin
                        psum_d      = acc_res[ACC_W-1:0];
                        acc_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // While the consumer stalls, drain_req is ignored and
                    // psum_out / out_valid hold.
                    if (out_ready) begin
                        if (drain_req) begin
                            // Back-to-back drain: reload and stay in HOLD.
                            psum_d = acc_res[ACC_W-1:0];
                            acc_d  = '0;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = ST_ACC;
                        end
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_out_q   <= '0;
            wgt_out_q   <= '0;
            psum_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            skip_q      <= '0;
            state_q     <= ST_ACC;
        end else begin
            act_out_q   <= act_out_d;
            wgt_out_q   <= wgt_out_d;
            psum_q      <= psum_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            skip_q      <= skip_d;
            state_q     <= state_d;
        end
    end

    assign act_out   = act_out_q;
    assign wgt_out   = wgt_out_q;
    assign psum_out  = psum_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_mac_pe_param.sv
// -----------------------------------------------------------------------------
// tb_mac_pe_param
//
// Directed bench for mac_pe_param. Two instances share all inputs:
//   dut_a : default parameters (SATURATE=1, CNT_W=16)
//   dut_b : SATURATE=0 (wrap) and CNT_W=3 (to reach counter saturation)
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mac_pe_param;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     en, row_en, col_en, mode;
    logic signed [DATA_W-1:0] act_in, wgt_in;
    logic signed [ACC_W-1:0]  psum_in;
    logic                     acc_clr, drain_req, out_ready;

    logic signed [DATA_W-1:0] a_act_out, a_wgt_out, b_act_out, b_wgt_out;
    logic signed [ACC_W-1:0]  a_psum, b_psum;
    logic                     a_valid, b_valid, a_sat, b_sat;
    logic [15:0]              a_skip;
    logic [2:0]               b_skip;

    mac_pe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .row_en(row_en), .col_en(col_en), .mode(mode),
        .act_in(act_in), .wgt_in(wgt_in), .act_out(a_act_out), .wgt_out(a_wgt_out),
        .psum_in(psum_in), .psum_out(a_psum), .acc_clr(acc_clr), .drain_req(drain_req),
        .out_valid(a_valid), .out_ready(out_ready), .sat_flag(a_sat), .skip_cnt(a_skip)
    );

    mac_pe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(1'b0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .row_en(row_en), .col_en(col_en), .mode(mode),
        .act_in(act_in), .wgt_in(wgt_in), .act_out(b_act_out), .wgt_out(b_wgt_out),
        .psum_in(psum_in), .psum_out(b_psum), .acc_clr(acc_clr), .drain_req(drain_req),
        .out_valid(b_valid), .out_ready(out_ready), .sat_flag(b_sat), .skip_cnt(b_skip)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ops(input int a, input int w, input int p);
        act_in  = DATA_W'(a);
        wgt_in  = DATA_W'(w);
        psum_in = ACC_W'(p);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; row_en = 1'b0; col_en = 1'b0; mode = 1'b0;
        acc_clr = 1'b0; drain_req = 1'b0; out_ready = 1'b0;
        ops(0, 0, 0);

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_psum", a_psum, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_skip", a_skip, 0);
        chk("rst_act_out", a_act_out, 0);

        // ---------------- mode 0 basic ----------------
        rst = 1'b1; en = 1'b1; row_en = 1'b1; col_en = 1'b1;
        ops(3, 4, 10); tick();
        chk("m0_basic_psum", a_psum, 22);
        chk("m0_basic_act_out", a_act_out, 3);
        chk("m0_basic_wgt_out", a_wgt_out, 4);
        chk("m0_basic_valid", a_valid, 0);

        // zero skip
        ops(0, 5, 50); tick();
        chk("m0_zero_psum", a_psum, 50);
        chk("m0_zero_skip", a_skip, 1);
        chk("m0_zero_skip_b", b_skip, 1);

        // global stall
        en = 1'b0; ops(2, 3, 100); tick();
        chk("m0_stall_psum", a_psum, 50);
        chk("m0_stall_act_out", a_act_out, 0);
        chk("m0_stall_wgt_out", a_wgt_out, 5);

        // row disabled: forwarding continues, sum holds
        en = 1'b1; row_en = 1'b0; tick();
        chk("m0_rowoff_psum", a_psum, 50);
        chk("m0_rowoff_act_out", a_act_out, 2);
        chk("m0_rowoff_wgt_out", a_wgt_out, 3);
        chk("m0_rowoff_skip", a_skip, 1);

        // positive overflow: 8388600 + 16129 = 8404729
        row_en = 1'b1; ops(127, 127, 8388600); tick();
        chk("m0_satpos_psum_a", a_psum, 8388607);
        chk("m0_satpos_flag_a", a_sat, 1);
        chk("m0_wrappos_psum_b", b_psum, -8372487);
        chk("m0_wrappos_flag_b", b_sat, 1);

        // negative overflow: -8388600 - 16256 = -8404856
        ops(-128, 127, -8388600); tick();
        chk("m0_satneg_psum_a", a_psum, -8388608);
        chk("m0_wrapneg_psum_b", b_psum, 8372360);

        // flag is sticky across normal operation
        ops(1, 1, 0); tick();
        chk("m0_sticky_psum", a_psum, 1);
        chk("m0_sticky_flag_a", a_sat, 1);
        chk("m0_sticky_flag_b", b_sat, 1);

        // ---------------- switch to mode 1 under reset ----------------
        rst = 1'b0; mode = 1'b1; tick();
        chk("m1_rst_sat", a_sat, 0);
        chk("m1_rst_psum", a_psum, 0);
        chk("m1_rst_skip", a_skip, 0);
        rst = 1'b1;

        // accumulate 6 + 20 - 6 = 20
        acc_clr = 1'b1; ops(2, 3, 0); tick();
        chk("m1_clr_valid", a_valid, 0);
        acc_clr = 1'b0; ops(4, 5, 0); tick();
        ops(-1, 6, 0); tick();
        drain_req = 1'b1; row_en = 1'b0; tick();
        chk("m1_drain_valid", a_valid, 1);
        chk("m1_drain_psum", a_psum, 20);

        // stalled consumer: value holds, (1,1) keeps accumulating,
        // a drain request while stalled is ignored
        drain_req = 1'b0; out_ready = 1'b0; row_en = 1'b1; ops(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("m1_hold%0d_psum", i), a_psum, 20);
            chk($sformatf("m1_hold%0d_valid", i), a_valid, 1);
            row_en    = 1'b0;
            drain_req = (i == 1);
        end
        drain_req = 1'b0; out_ready = 1'b1; tick();
        chk("m1_accept_valid", a_valid, 0);
        out_ready = 1'b0; drain_req = 1'b1; tick();
        chk("m1_drain2_psum", a_psum, 1);
        chk("m1_drain2_valid", a_valid, 1);

        // back-to-back: acc=4, then drain+ready with product 3 -> 7
        drain_req = 1'b0; row_en = 1'b1; ops(2, 2, 0); tick();
        chk("m1_b2b_pre_psum", a_psum, 1);
        drain_req = 1'b1; out_ready = 1'b1; ops(3, 1, 0); tick();
        chk("m1_b2b_psum", a_psum, 7);
        chk("m1_b2b_valid", a_valid, 1);

        drain_req = 1'b0; row_en = 1'b0; tick();
        chk("m1_b2b_accept_valid", a_valid, 0);

        // acc_clr + drain together: captures product, leaves acc at 0
        acc_clr = 1'b1; drain_req = 1'b1; out_ready = 1'b0; row_en = 1'b1; ops(5, -2, 0); tick();
        chk("m1_clrdrain_psum", a_psum, -10);
        chk("m1_clrdrain_valid", a_valid, 1);
        acc_clr = 1'b0; out_ready = 1'b1; row_en = 1'b0; tick();
        chk("m1_clrdrain_acc0", a_psum, 0);

        // zero skip counted in mode 1
        drain_req = 1'b0; row_en = 1'b1; ops(0, 7, 0); tick();
        chk("m1_skip", a_skip, 1);
        chk("m1_skip_valid", a_valid, 0);

        // accumulator overflow: 600 * 16129 = 9677400
        out_ready = 1'b0; ops(127, 127, 0);
        for (int i = 0; i < 600; i++) tick();
        chk("m1_ovf_flag_a", a_sat, 1);
        chk("m1_ovf_flag_b", b_sat, 1);
        drain_req = 1'b1; row_en = 1'b0; tick();
        chk("m1_ovf_psum_a", a_psum, 8388607);
        chk("m1_ovf_psum_b", b_psum, -7099816);
        drain_req = 1'b0; out_ready = 1'b1; acc_clr = 1'b1; tick();
        chk("m1_clr_flag_a", a_sat, 0);
        chk("m1_clr_flag_b", b_sat, 0);
        chk("m1_clr_valid2", a_valid, 0);

        // reset mid-HOLD
        acc_clr = 1'b0; out_ready = 1'b0; row_en = 1'b1; ops(3, 3, 0); tick();
        drain_req = 1'b1; row_en = 1'b0; tick();
        chk("m1_pre_rst_psum", a_psum, 9);
        chk("m1_pre_rst_valid", a_valid, 1);
        chk("m1_pre_rst_skip", a_skip, 1);
        rst = 1'b0; drain_req = 1'b0; tick();
        chk("m1_rst_valid", a_valid, 0);
        chk("m1_rst_psum2", a_psum, 0);
        chk("m1_rst_skip2", a_skip, 0);
        chk("m1_rst_sat2", a_sat, 0);
        rst = 1'b1;

        // skip counter saturation (dut_b is 3 bits wide)
        row_en = 1'b1; ops(0, 1, 0);
        for (int i = 0; i < 9; i++) tick();
        chk("skip_count_a", a_skip, 9);
        chk("skip_sat_b", b_skip, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_pe_param.md
# mac_pe_param

Parametrised successor to the fixed 8/24-bit systolic MAC processing element for the 8x8 array. Generic in operand and accumulator width, with two dataflow modes:
- pass-sum (weight-stationary/systolic): the partial sum flows through the PE.
- output-stationary: a local accumulator is drained over a valid/ready handshake.

The block adds optional saturation, a sticky overflow flag and a zero-skip counter for sparsity statistics. It is instantiated once per array cell. Activation and weight move right and down through registered forwarding ports.

## Interface
- DATA_W, 8, signed activation/weight width
- ACC_W, 24, signed accumulator / partial-sum width; must satisfy ACC_W >= 2*DATA_W+1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- CNT_W, 16, zero-skip counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst=0 resets)
- en  in  1  global enable; 0 stalls MAC and forwarding
- row_en, col_en  in  1  PE active only when en & row_en & col_en
- mode  in  1  0 = pass-sum, 1 = output-stationary; quasi-static
- act_in, wgt_in  in  DATA_W  signed operands
- act_out, wgt_out  out  DATA_W  registered forward of act_in/wgt_in
- psum_in  in  ACC_W  signed upstream partial sum (mode 0 only)
- psum_out  out  ACC_W  mode 0: registered sum; mode 1: drained accumulator value
- acc_clr  in  1  mode 1: clear the local accumulator
- drain_req  in  1  mode 1: capture the accumulator for output
- out_valid  out  1  psum_out holds a valid drained value (mode 1)
- out_ready  in  1  downstream accepts psum_out
- sat_flag  out  1  sticky overflow indicator
- skip_cnt  out  CNT_W  count of zero-skipped active cycles

## Operation
- active = en & row_en & col_en.
- zero = (act_in==0) | (wgt_in==0).
- prod = sign-extended DATA_W x DATA_W signed product; forced to 0 when zero (multiplier operands gated).
- Forwarding: when en=1, act_out<=act_in and wgt_out<=wgt_in, regardless of row_en/col_en. When en=0, both hold.
- Mode 0 (pass-sum), when active:
  - psum_out <= sat(psum_in + prod).
  - When zero, psum_out <= psum_in exactly.
  - When not active, psum_out holds.
  - out_valid stays 0.
- Mode 1 (output-stationary), two states: ACC and HOLD (out_valid=1).
  - ACC, active: acc <= sat(acc + prod).
  - acc_clr=1: acc <= prod if active, else 0. Clearing takes priority over the old value, not over the current product.
  - drain_req=1 in ACC: psum_out <= sat(acc + (active ? prod : 0)); acc <= 0; out_valid <= 1; go to HOLD.
  - HOLD: accumulation continues into the cleared acc (double-buffered).
  - HOLD with out_ready=1: out_valid <= 0, return to ACC. If drain_req is also 1, reload psum_out and remain in HOLD (back-to-back drain).
  - HOLD with out_ready=0: drain_req is ignored; psum_out and out_valid hold.
  - The handshake runs regardless of en, row_en and col_en.
  - acc_clr and drain_req together: drain captures, acc <= 0.
- Arithmetic:
  - SATURATE=1: results clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sat_flag sets.
  - SATURATE=0: results wrap, and sat_flag still sets on overflow detection.
  - sat_flag clears only on reset or acc_clr in mode 1.
- skip_cnt increments on every active & zero cycle, in either mode. It saturates at all-ones and does not wrap.
- mode may change only while rst=0; behaviour is unspecified otherwise.

## Timing
- Reset (rst=0 at a clock edge) forces all of the following to 0: act_out, wgt_out, psum_out, out_valid, sat_flag, skip_cnt, acc. The FSM goes to ACC.
- Reset mid-drain discards the pending value; out_valid=0 the next cycle.
- Mode 0 latency: 1 cycle from psum_in/act_in/wgt_in to psum_out.
- Mode 1: out_valid rises 1 cycle after the drain_req edge. psum_out is stable while out_valid=1 and out_ready=0.
- Forwarding latency: 1 cycle; the array skew is produced by PE chaining.
- The critical path is one multiply plus one ACC_W add plus the clamp. There is no internal pipelining.

## Test plan
- Mode 0 basic: act=3, wgt=4, psum_in=10, all enables 1 -> psum_out=22 after 1 cycle; act_out=3, wgt_out=4.
- Mode 0 zero-skip and stall:
  - act=0, wgt=5, psum_in=50 -> psum_out=50 and skip_cnt increments by 1.
  - Then en=0 with act=2, wgt=3, psum_in=100 -> psum_out stays 50 and act_out/wgt_out hold.
- Mode 0 saturation (defaults): psum_in=8388600, act=127, wgt=127 -> psum_out=8388607, sat_flag=1. Repeat with SATURATE=0 -> wrapped value, sat_flag=1.
- Mode 1 accumulate/drain:
  - acc_clr with (2,3), then (4,5) and (-1,6) -> drain_req gives psum_out=20 with out_valid=1 one cycle later.
  - With out_ready held 0 for 3 cycles, the value holds. New products (1,1) keep accumulating, and the next drain yields 1.
- Mode 1 boundaries:
  - drain_req and out_ready in the same HOLD cycle -> back-to-back reload.
  - acc_clr and drain_req together -> captured value includes the current product, and acc becomes 0.
- Reset mid-HOLD (rst=0 for one cycle) -> out_valid=0, psum_out=0, skip_cnt=0, sat_flag=0 on the next edge.
